// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Iteration counter width for a given operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/muldiv_sfix.sv
// Sign fix-up: negates the double-width product as a whole, or the
// quotient and remainder words independently.
import muldiv_pkg::*;

module muldiv_sfix #(
  parameter int WIDTH = 8
) (
  input  logic             div_i,
  input  logic             neg_lo_i,
  input  logic             neg_hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic [2*WIDTH-1:0] prod, prod_n;

  assign prod   = {hi_i, lo_i};
  assign prod_n = -prod;

  // Multiply uses neg_lo_i as the product sign; divide uses both flags.
  always_comb begin
    lo_o = lo_i;
    hi_o = hi_i;
    if (div_i) begin
      lo_o = neg_lo_i ? -lo_i : lo_i;
      hi_o = neg_hi_i ? -hi_i : hi_i;
    end else begin
      {hi_o, lo_o} = neg_lo_i ? prod_n : prod;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit. Signed ops work on
// magnitudes during RUN and are corrected in FIX, so latency is always
// WIDTH+1 cycles from the accepting edge to oDONE.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [1:0]       iOP,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oDIVZ,
  output logic [WIDTH-1:0] oLO,
  output logic [WIDTH-1:0] oHI
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;    // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] hi_q;       // upper accumulator / partial remainder
  logic [WIDTH-1:0] lo_q;       // multiplier bits / dividend bits -> quotient
  logic             div_q, nlo_q, nhi_q;
  logic             busy_q, done_q, divz_q;
  logic [WIDTH-1:0] olo_q, ohi_q;

  logic             op_div, op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum, dsh, ddiff;
  logic [WIDTH-1:0] step_hi, step_lo, fix_lo, fix_hi;
  logic             fix_divz;

  // Operand decode: magnitudes and signs taken at the accepting edge.
  always_comb begin
    op_div = (iOP == OP_DIVU) || (iOP == OP_DIVS);
    op_sgn = (iOP == OP_MULS) || (iOP == OP_DIVS);
    a_neg  = op_sgn && iA[WIDTH-1];
    b_neg  = op_sgn && iB[WIDTH-1];
    a_mag  = a_neg ? -iA : iA;
    b_mag  = b_neg ? -iB : iB;
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  // The remainder is always below the divisor, so a (WIDTH+1)-bit trial
  // difference is enough and its top bit is the borrow.
  always_comb begin
    msum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    dsh   = {hi_q, lo_q[WIDTH-1]};
    ddiff = dsh - {1'b0, mcand_q};
    if (div_q) begin
      step_hi = ddiff[WIDTH] ? dsh[WIDTH-1:0] : ddiff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~ddiff[WIDTH]};
    end else begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign fix_divz = div_q && (mcand_q == '0);

  // With a zero divisor the remainder register ends up holding |A|, and
  // the dividend-sign fix-up turns it back into A; only the quotient
  // needs overriding.
  muldiv_sfix #(.WIDTH(WIDTH)) u_sfix (
    .div_i    (div_q),
    .neg_lo_i (nlo_q),
    .neg_hi_i (nhi_q),
    .lo_i     (lo_q),
    .hi_i     (hi_q),
    .lo_o     (fix_lo),
    .hi_o     (fix_hi)
  );

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      nlo_q   <= 1'b0;
      nhi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      olo_q   <= '0;
      ohi_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (iSTART) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            mcand_q <= op_div ? b_mag : a_mag;
            lo_q    <= op_div ? a_mag : b_mag;
            hi_q    <= '0;
            div_q   <= op_div;
            nlo_q   <= a_neg ^ b_neg;
            nhi_q   <= op_div && a_neg;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          olo_q   <= fix_divz ? '1 : fix_lo;
          ohi_q   <= fix_hi;
          divz_q  <= fix_divz;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oBUSY = busy_q;
  assign oDONE = done_q;
  assign oDIVZ = divz_q;
  assign oLO   = olo_q;
  assign oHI   = ohi_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide coprocessor for the processor core, succeeding the single-cycle 8-bit multiplier and its high-byte register.
- Computes the full double-width product (unsigned or signed), or quotient and remainder (unsigned or signed), for WIDTH-bit operands.
- Uses a shift-add / restoring-divide datapath that retires one bit per cycle.
- Sits beside the ALU: the instruction decoder pulses a start, polls busy/done, and routes the low/high result registers into the GPR write mux.

## Interface
- WIDTH, default 8: operand width; results are two WIDTH-bit words; legal range 4..32.
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iSTART  in  1  start request; sampled every edge, acted on only in IDLE or DONE.
- iOP  in  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- iA  in  WIDTH  multiplicand / dividend.
- iB  in  WIDTH  multiplier / divisor.
- oBUSY  out  1  operation in progress.
- oDONE  out  1  result valid; held high until the next accepted start or reset.
- oDIVZ  out  1  the last completed division had a zero divisor.
- oLO  out  WIDTH  product low word / quotient.
- oHI  out  WIDTH  product high word / remainder.

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE -start-> RUN.
  - RUN -after WIDTH iterations-> FIX.
  - FIX -> DONE.
  - DONE -start-> RUN.
- Accepting a start:
  - iA, iB and iOP are latched into internal registers.
  - Signed ops (01, 11) latch operand magnitudes plus the result-sign and remainder-sign bits.
  - The iteration counter clears.
- Operands are not re-sampled while busy.
- RUN, multiply: each cycle conditionally adds the multiplicand to the upper accumulator, then shifts right by one.
- RUN, divide: each cycle shifts the remainder left, trial-subtracts the divisor, and sets the quotient bit when the result is ≥ 0.
- FIX:
  - Applies two's-complement negation where the sign bits require it.
  - Signed multiply: negates the full 2·WIDTH product when exactly one operand is negative.
  - Signed divide: truncates toward zero; the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
- FIX loads oLO, oHI and oDIVZ. These are written only on the FIX->DONE edge and hold their previous values during RUN/FIX.
- Divide by zero:
  - Both DIVU and DIVS give quotient all-ones and remainder = iA; oDIVZ=1.
  - No exception is raised and latency is unchanged.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder 0, oDIVZ=0.
- oDIVZ is cleared on completion of any multiply or any nonzero-divisor divide.
- iSTART while in RUN or FIX is ignored, with no queueing.
- iOP/iA/iB changes during busy have no effect.
- Reset, including mid-operation:
  - State goes to IDLE and counter and internal registers clear.
  - oLO=0, oHI=0, oBUSY=0, oDONE=0, oDIVZ=0.
  - The aborted result is discarded.

## Timing
- Start accepted at edge k:
  - oBUSY is high after edges k through k+WIDTH (WIDTH+1 cycles).
  - oDONE rises after edge k+WIDTH+1, together with valid oLO/oHI/oDIVZ.
- Latency is fixed at WIDTH+1 cycles for every op and operand value, including zero divisor and unsigned ops (FIX is always traversed).
- oBUSY and oDONE are mutually exclusive and are never both low while a result is pending.
- Back-to-back operation:
  - A start in the DONE cycle takes effect at that edge: oDONE falls and oBUSY rises on the same edge.
  - Throughput is one op per WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package muldiv_pkg holds:
  - Op-code constants OP_MULU/OP_MULS/OP_DIVU/OP_DIVS.
  - State encoding constants ST_IDLE/ST_RUN/ST_FIX/ST_DONE.
  - Counter width as $clog2(WIDTH)+1.
- One sub-module, muldiv_sfix: combinational conditional negation of a 2·WIDTH word (MULS) or of independent quotient/remainder words (DIVS), parametrised by WIDTH. Used in FIX.
- Top level holds the FSM, counter, operand/accumulator registers and output registers.

## Test plan (WIDTH=8 unless noted)
- MULU 0xFF×0xFF -> oLO=0x01, oHI=0xFE. oDONE rises exactly 9 cycles after the start edge, and oBUSY is high for exactly 9 cycles.
- MULS 0xFE×0x03 -> 0xFA/0xFF. MULS 0x80×0x80 -> 0x00/0x40.
- DIVU 0xC8/0x07 -> q=0x1C, r=0x04. DIVS 0xF9/0x02 -> q=0xFD, r=0xFF. DIVS 0x07/0xFE -> q=0xFD, r=0x01.
- DIVU 0x2A/0x00 -> 0xFF/0x2A with oDIVZ=1. Next, DIVS 0x80/0xFF -> 0x80/0x00 with oDIVZ=0.
- Busy and reset behaviour:
  - A second iSTART mid-RUN with new operands is ignored; the original result is delivered.
  - A start in the DONE cycle restarts with no idle gap.
  - iRST asserted in cycle 4 of RUN immediately zeroes all outputs, and the next start completes correctly.
- WIDTH=16, random 10k operands per op checked against a reference model, with latency 17 verified on every op.
